// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = 3;

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter, emits bit_tick on the last cycle of each bit
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_tick = en && (count == LAST);

  // Held at zero while disabled so the first bit after an accept is full length.
  always_ff @(posedge clk) begin
    if (rst || !en || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - UART frame sequencer driving an external PISO and the tx line
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] piso_data_o,
  output logic       piso_load_o,
  output logic       piso_shift_en_o,
  input  logic       piso_bit_i,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  tx_state_t            state;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic                 parity_bit;
  logic                 stop_cnt;
  logic                 baud_en;
  logic                 bit_tick;
  logic                 accept;
  logic                 last_data_bit;
  logic                 last_stop_bit;

  assign baud_en = (state != IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (baud_en),
    .bit_tick(bit_tick)
  );

  assign tx_ready_o      = (state == IDLE) && !rst;
  assign accept          = tx_valid_i && tx_ready_o;
  assign piso_data_o     = tx_data_i;
  assign piso_load_o     = accept;
  assign last_data_bit   = (bit_idx == BIT_IDX_W'(DATA_BITS - 1));
  assign last_stop_bit   = (int'(stop_cnt) == STOP_BITS - 1);
  // The PISO already presents bit 0 after the load, so only 7 shifts per byte.
  assign piso_shift_en_o = !rst && (state == DATA) && bit_tick && !last_data_bit;
  assign tx_busy_o       = (state != IDLE);

  always_comb begin
    tx_o = 1'b1;
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = piso_bit_i;
      PARITY:  tx_o = parity_bit;
      default: tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      stop_cnt   <= 1'b0;
      tx_done_o  <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= START;
            parity_bit <= (^tx_data_i) ^ (PARITY_ODD != 0);
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (last_data_bit) begin
              state    <= (PARITY_EN != 0) ? PARITY : STOP;
              stop_cnt <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (last_stop_bit) begin
              state     <= IDLE;
              tx_done_o <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// tb/tb_uart_tx_controller.sv - scoreboard bench over four parameter variants of uart_tx_controller
module tb_uart_tx_controller;

  localparam int CPB = 4;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid, ready, load, shift, pbit, tx, busy, done;
  logic [7:0] data      [4];
  logic [7:0] piso_data [4];

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instance 0: no parity, 1 stop; 1: even parity; 2: odd parity; 3: 2 stop bits.
  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int PEN = (g == 1 || g == 2) ? 1 : 0;
    localparam int POD = (g == 2) ? 1 : 0;
    localparam int SB  = (g == 3) ? 2 : 1;
    localparam int NB  = 10 + PEN + SB - 1;

    logic [7:0]  piso_q = 8'h00;
    logic [11:0] exp_bits;
    int          bit_n, cyc_n, shifts;
    bit          active = 1'b0;
    bit          pend_done = 1'b0;
    sb_t         e;

    uart_tx_controller #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PEN),
      .PARITY_ODD  (POD),
      .STOP_BITS   (SB)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .tx_data_i      (data[g]),
      .tx_valid_i     (valid[g]),
      .tx_ready_o     (ready[g]),
      .piso_data_o    (piso_data[g]),
      .piso_load_o    (load[g]),
      .piso_shift_en_o(shift[g]),
      .piso_bit_i     (pbit[g]),
      .tx_o           (tx[g]),
      .tx_busy_o      (busy[g]),
      .tx_done_o      (done[g])
    );

    always @(posedge clk) begin
      if (load[g]) piso_q <= piso_data[g];
      else if (shift[g]) piso_q <= {1'b0, piso_q[7:1]};
    end
    assign pbit[g] = piso_q[0];

    always @(negedge clk) begin
      check("load_shift_excl", 32'(load[g] & shift[g]), 32'd0);
      if (done[g] || pend_done) check("done", 32'(done[g]), 32'(pend_done));
      pend_done = 1'b0;
      if (active) begin
        check("tx_bit", 32'(tx[g]), 32'(exp_bits[bit_n]));
        check("busy_frame", 32'(busy[g]), 32'd1);
        check("ready_frame", 32'(ready[g]), 32'd0);
        check("load_frame", 32'(load[g]), 32'd0);
        if (rst) begin
          check("shift_rst", 32'(shift[g]), 32'd0);
          active = 1'b0;
        end else begin
          shifts += int'(shift[g]);
          cyc_n++;
          if (cyc_n == CPB) begin
            cyc_n = 0;
            bit_n++;
          end
          if (bit_n == NB) begin
            active    = 1'b0;
            pend_done = 1'b1;
            check("shift_count", 32'(shifts), 32'd7);
          end
        end
      end else begin
        check("tx_idle", 32'(tx[g]), 32'd1);
        check("busy_idle", 32'(busy[g]), 32'd0);
        check("shift_idle", 32'(shift[g]), 32'd0);
        check("ready_idle", 32'(ready[g]), 32'(!rst));
        check("load_idle", 32'(load[g]), 32'(valid[g] && !rst));
        if (valid[g] && !rst) begin
          if (sb_q.size() == 0) begin
            check("unexpected_accept", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("sb_idx", 32'(e.idx), 32'(g));
            check("load_data", 32'(piso_data[g]), 32'(e.data));
            exp_bits    = '1;
            exp_bits[0] = 1'b0;
            for (int k = 0; k < 8; k++) exp_bits[1 + k] = e.data[k];
            if (PEN != 0) begin
              if (POD != 0) exp_bits[9] = ($countones(e.data) % 2 == 0);
              else          exp_bits[9] = ($countones(e.data) % 2 == 1);
            end
            active = 1'b1;
            cyc_n  = 0;
            bit_n  = 0;
            shifts = 0;
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [7:0] b);
    int n;
    sb_q.push_back('{idx: 2'(i), data: b});
    @(posedge clk);
    #1;
    valid[i] = 1'b1;
    data[i]  = b;
    n = 0;
    while (!ready[i] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_timeout", 32'(ready[i]), 32'd1);
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done[i] && n < budget);
    check("done_timeout", 32'(done[i]), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    valid = '0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    send(0, 8'hA5);
    wait_done(0, 100);
    send(1, 8'h07);
    wait_done(1, 100);
    send(2, 8'h07);
    wait_done(2, 100);
    send(3, 8'h00);
    wait_done(3, 100);

    sb_q.push_back('{idx: 2'd0, data: 8'h55});
    sb_q.push_back('{idx: 2'd0, data: 8'h0F});
    @(posedge clk);
    #1;
    valid[0] = 1'b1;
    data[0]  = 8'h55;
    @(posedge clk);
    #1;
    data[0] = 8'h0F;
    repeat (10) @(posedge clk);
    #1;
    data[0] = 8'hFF;
    @(posedge clk);
    #1;
    data[0] = 8'h0F;
    wait_done(0, 100);
    check("b2b_ready_in_done", 32'(ready[0]), 32'd1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    wait_done(0, 100);

    send(0, 8'hC3);
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(0, 8'h3C);
    wait_done(0, 100);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_controller.md
Name: uart_tx_controller

Overview:
- Sequences the transmitter PISO shift register to produce a complete UART frame: start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Owns bit timing (baud counter), the byte-accept handshake, and the PISO load and shift strobes.
- Drives the serial tx line.
- Sits between the host-side byte source and the PISO; the PISO supplies the current data bit back to this block.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (legal range >= 2)
- PARITY_EN, 0, 1 = insert a parity bit after the data bits
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0)
- STOP_BITS, 1, number of stop bits (legal values 1 or 2)

Ports:
- clk  input  1  system clock
- rst  input  1  reset: one clock; reset is synchronous and active-high
- tx_data_i  input  8  byte to send
- tx_valid_i  input  1  byte on tx_data_i is valid
- tx_ready_o  output  1  controller can accept a byte this cycle
- piso_data_o  output  8  parallel load data to the PISO (combinational copy of tx_data_i)
- piso_load_o  output  1  PISO parallel-load strobe
- piso_shift_en_o  output  1  PISO shift strobe
- piso_bit_i  input  1  current PISO serial output (bit 0)
- tx_o  output  1  UART serial line, idle high
- tx_busy_o  output  1  frame in progress (state != IDLE)
- tx_done_o  output  1  one-cycle pulse when a frame completes

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values (rst high at a clock edge):
  - state = IDLE; baud counter = 0; bit index = 0; parity reg = 0; tx_done_o = 0.
  - tx_o = 1; tx_busy_o = 0.
- While rst is high, tx_ready_o = 0, piso_load_o = 0 and piso_shift_en_o = 0. rst has priority over every other event.
- tx_ready_o = (state == IDLE) && !rst.
- Accept occurs when tx_valid_i && tx_ready_o. In the accept cycle:
  - piso_load_o = 1, so the PISO holds the byte from the next cycle.
  - The parity register captures ^tx_data_i XOR PARITY_ODD.
  - At the edge: state moves to START, baud counter = 0.
- tx_valid_i while not ready is ignored: no load, no state change.
- bit_tick = (baud counter == CLKS_PER_BIT-1). The counter increments every non-IDLE cycle and wraps to 0 on bit_tick. Counter width is $clog2(CLKS_PER_BIT).
- START:
  - tx_o = 0.
  - On bit_tick: go to DATA, bit index = 0.
- DATA:
  - tx_o = piso_bit_i.
  - On bit_tick with bit index < 7: piso_shift_en_o = 1 for that cycle; bit index increments.
  - On bit_tick with bit index == 7: no shift; go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - tx_o = parity register.
  - On bit_tick: go to STOP, stop count = 0.
- STOP:
  - tx_o = 1.
  - Each bit_tick increments the stop count. The bit_tick on which the stop count reaches STOP_BITS-1 returns the state to IDLE and registers tx_done_o = 1 for exactly one cycle (the first IDLE cycle).
- Frame length: accept at edge k, IDLE re-entered at edge k + (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT.
- Back-to-back: a byte may be accepted in the same cycle tx_done_o is high. There is no extra idle gap.
- tx_o is decoded from the state register, the parity register and piso_bit_i only (all flop outputs), so it has no glitch within a bit period.
- Reset mid-frame: the frame is aborted and tx_o = 1 from the next cycle. The partial frame is not reported; tx_done_o stays 0. The PISO contents are don't-care because the next accept reloads them.
- piso_load_o and piso_shift_en_o are never asserted in the same cycle.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - localparam DATA_BITS = 8
  - localparam BIT_IDX_W = 3
- One sub-module, uart_baud_counter:
  - Parameter CLKS_PER_BIT; inputs clk, rst, en; output bit_tick.
  - Clears when en = 0.

Test Plan (CLKS_PER_BIT=4 unless stated):
- rst high 2 cycles, then low -> tx_o=1 and tx_busy_o=0 throughout; tx_ready_o=0 during rst and 1 from the first cycle after; no load/shift strobes.
- Send 0xA5, PARITY_EN=0, STOP_BITS=1 -> one piso_load_o pulse; tx_o = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; exactly 7 piso_shift_en_o pulses; tx_done_o 40 cycles after accept; tx_ready_o low for those 40 cycles.
- Send 0x07 with PARITY_EN=1, PARITY_ODD=0 -> parity bit 1, frame 44 cycles; repeat with PARITY_ODD=1 -> parity bit 0.
- Hold tx_valid_i high, presenting 0x55 then 0x0F -> second accept occurs in the tx_done_o cycle; the start bit follows the stop bit with no idle cycles; 0xFF pulsed for 1 cycle mid-frame is never loaded or sent.
- STOP_BITS=2, send 0x00 -> stop level lasts 8 cycles; total frame 44 cycles.
- Assert rst during DATA bit 3 of 0xC3 -> tx_o=1 next cycle, no tx_done_o; after release, a fresh 0x3C frame is transmitted correctly.
